duc_pkt_framer: RTL and testbench

DUC_PKT_FRAMER -- requirements
Module: duc_pkt_framer

---
 rtl/duc_pkt_framer_pkg.sv | 21 ++
 rtl/axi_fifo_flop2.sv | 35 +++
 rtl/duc_pkt_framer.sv | 144 ++++++++++++++
 tb/tb_duc_pkt_framer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/duc_pkt_framer_pkg.sv
// Shared types and default widths for the DUC packet framer.
package duc_pkt_framer_pkg;

    localparam int ITEM_W_DEF = 32;
    localparam int TIME_W_DEF = 64;
    localparam int LEN_W_DEF  = 16;
    localparam int RATE_W_DEF = 11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [TIME_W_DEF-1:0] ts;
        logic                  has_time;
        logic                  eob;
        logic [LEN_W_DEF-1:0]  len;
    } hdr_t;

endpackage

// File: rtl/axi_fifo_flop2.sv
// Single registered AXI-stream stage; advances whenever the consumer is ready,
// so a stalled consumer freezes the held beat and stops intake.
module axi_fifo_flop2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    assign s_tready = m_tready;
    assign m_tdata  = data_reg;
    assign m_tvalid = valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (m_tready) begin
            valid_reg <= s_tvalid;
            if (s_tvalid) begin
                data_reg <= s_tdata;
            end
        end
    end

endmodule

// File: rtl/duc_pkt_framer.sv
// Frames the interpolated DUC sample stream into packets of cfg_spp samples,
// carrying per-packet timestamp, has_time and end-of-burst sideband.
module duc_pkt_framer
    import duc_pkt_framer_pkg::*;
#(
    parameter int ITEM_W = ITEM_W_DEF,
    parameter int TIME_W = TIME_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic              ce_clk,
    input  logic              ce_rst_n,
    input  logic [LEN_W-1:0]  cfg_spp,
    input  logic [RATE_W-1:0] cfg_interp,
    input  logic [TIME_W-1:0] s_hdr_time,
    input  logic              s_hdr_has_time,
    input  logic              s_hdr_eob,
    input  logic [LEN_W-1:0]  s_hdr_len,
    input  logic              s_hdr_tvalid,
    output logic              s_hdr_tready,
    input  logic [ITEM_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [ITEM_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [TIME_W-1:0] m_time,
    output logic              m_has_time,
    output logic              m_eob
);

    localparam int TOT_W = LEN_W + RATE_W;
    localparam int PAY_W = ITEM_W + TIME_W + 3;

    state_t            state_reg, state_next;
    logic              armed_reg;
    logic [TOT_W-1:0]  remaining_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic [LEN_W-1:0]  spp_reg;
    logic [TIME_W-1:0] time_reg;
    logic              has_time_reg;
    logic              eob_reg;

    hdr_t              hdr;
    logic [TOT_W-1:0]  total;
    logic [TOT_W:0]    pkt_rem;
    logic              hdr_fire;
    logic              push;
    logic              out_ready;
    logic              beat_last;
    logic              beat_eob;
    logic [PAY_W-1:0]  payload;
    logic [PAY_W-1:0]  stage_out;

    assign hdr = '{ts: s_hdr_time, has_time: s_hdr_has_time, eob: s_hdr_eob, len: s_hdr_len};
    assign total = TOT_W'(hdr.len) * TOT_W'(cfg_interp);

    assign hdr_fire = s_hdr_tvalid & s_hdr_tready;
    assign push     = s_tvalid & s_tready;

    assign beat_last = (cnt_reg == spp_reg - LEN_W'(1)) || (remaining_reg == TOT_W'(1));
    // Remaining count at the start of the current packet decides whether it is the final one.
    assign pkt_rem  = {1'b0, remaining_reg} + {{(RATE_W + 1){1'b0}}, cnt_reg};
    assign beat_eob = eob_reg && (pkt_rem <= {{(RATE_W + 1){1'b0}}, spp_reg});

    assign payload = {beat_eob, has_time_reg, time_reg, beat_last, s_tdata};

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        s_hdr_tready = 1'b0;
        s_tready     = 1'b0;
        case (state_reg)
            IDLE: begin
                s_hdr_tready = armed_reg;
                if (armed_reg && s_hdr_tvalid && (total != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                s_tready = out_ready && (remaining_reg != '0);
                // Stay in RUN until the final beat has left the output register.
                if ((remaining_reg == '0) && m_tvalid && m_tready && m_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            armed_reg     <= 1'b0;
            remaining_reg <= '0;
            cnt_reg       <= '0;
            spp_reg       <= '0;
            time_reg      <= '0;
            has_time_reg  <= 1'b0;
            eob_reg       <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            if (hdr_fire) begin
                remaining_reg <= total;
                cnt_reg       <= '0;
                spp_reg       <= (cfg_spp == '0) ? LEN_W'(1) : cfg_spp;
                time_reg      <= hdr.ts;
                has_time_reg  <= hdr.has_time;
                eob_reg       <= hdr.eob;
            end else if (push) begin
                remaining_reg <= remaining_reg - TOT_W'(1);
                if (beat_last) begin
                    cnt_reg  <= '0;
                    time_reg <= time_reg + TIME_W'(cnt_reg) + TIME_W'(1);
                end else begin
                    cnt_reg <= cnt_reg + LEN_W'(1);
                end
            end
        end
    end

    axi_fifo_flop2 #(
        .WIDTH(PAY_W)
    ) u_out (
        .clk     (ce_clk),
        .rst_n   (ce_rst_n),
        .s_tdata (payload),
        .s_tvalid(push),
        .s_tready(out_ready),
        .m_tdata (stage_out),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready)
    );

    assign {m_eob, m_has_time, m_time, m_tlast, m_tdata} = stage_out;

endmodule

// File: tb/tb_duc_pkt_framer.sv
// Directed bench for duc_pkt_framer: header table replayed through a cycle loop
// with a small packetisation model, plus reset corner sequences.
module tb_duc_pkt_framer;

    logic        ce_clk = 1'b0;
    logic        ce_rst_n = 1'b0;
    logic [15:0] cfg_spp = '0;
    logic [10:0] cfg_interp = '0;
    logic [63:0] s_hdr_time = '0;
    logic        s_hdr_has_time = 1'b0;
    logic        s_hdr_eob = 1'b0;
    logic [15:0] s_hdr_len = '0;
    logic        s_hdr_tvalid = 1'b0;
    logic        s_hdr_tready;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [63:0] m_time;
    logic        m_has_time;
    logic        m_eob;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          spp;
        int          interp;
        int          len;
        logic [63:0] tm;
        bit          ht;
        bit          eob;
        int          stall;
        int          pkts;
        int          last;
        logic [63:0] t2;
    } vec_t;

    vec_t vecs[8];

    always #5 ce_clk = ~ce_clk;

    duc_pkt_framer dut (
        .ce_clk        (ce_clk),
        .ce_rst_n      (ce_rst_n),
        .cfg_spp       (cfg_spp),
        .cfg_interp    (cfg_interp),
        .s_hdr_time    (s_hdr_time),
        .s_hdr_has_time(s_hdr_has_time),
        .s_hdr_eob     (s_hdr_eob),
        .s_hdr_len     (s_hdr_len),
        .s_hdr_tvalid  (s_hdr_tvalid),
        .s_hdr_tready  (s_hdr_tready),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tlast       (m_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_time        (m_time),
        .m_has_time    (m_has_time),
        .m_eob         (m_eob)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic send_hdr(input int spp, input int interp, input int len,
                            input logic [63:0] tm, input bit ht, input bit eob);
        int n;
        @(posedge ce_clk); #1;
        cfg_spp        = 16'(spp);
        cfg_interp     = 11'(interp);
        s_hdr_time     = tm;
        s_hdr_has_time = ht;
        s_hdr_eob      = eob;
        s_hdr_len      = 16'(len);
        s_hdr_tvalid   = 1'b1;
        n = 0;
        do begin
            @(negedge ce_clk);
            n++;
        end while (!s_hdr_tready && n < 100);
        check("hdr_accept", 64'(s_hdr_tready), 64'd1);
        @(posedge ce_clk); #1;
        s_hdr_tvalid = 1'b0;
        // Scramble config: it must not affect the burst in flight.
        cfg_spp    = 16'd7;
        cfg_interp = 11'd1;
    endtask

    task automatic run_case(input vec_t v, input int seed);
        int total, spp_eff, sent, rcv, pkt, idx, pstart, plen, rem, cyc, last_len, extra, n;
        bit stalled;
        logic [63:0] t2;
        total   = v.len * v.interp;
        spp_eff = (v.spp == 0) ? 1 : v.spp;
        send_hdr(v.spp, v.interp, v.len, v.tm, v.ht, v.eob);
        sent = 0; rcv = 0; pkt = 0; idx = 0; pstart = 0; cyc = 0; last_len = 0;
        stalled = 1'b0;
        t2 = '0;
        while (rcv < total && cyc < total * 8 + 200) begin
            m_tready = ($urandom_range(99) >= 32'(v.stall));
            s_tvalid = (sent < total) && ($urandom_range(99) >= 32'(v.stall));
            s_tdata  = 32'(seed + sent);
            @(negedge ce_clk);
            cyc++;
            if (stalled) check("hold_valid", 64'(m_tvalid), 64'd1);
            if (m_tvalid) check("data", 64'(m_tdata), 64'(32'(seed + rcv)));
            if (s_tvalid && s_tready) sent++;
            stalled = m_tvalid && !m_tready;
            if (m_tvalid && m_tready) begin
                rem  = total - pstart;
                plen = (rem < spp_eff) ? rem : spp_eff;
                check("tlast", 64'(m_tlast), 64'(idx == plen - 1));
                check("eob", 64'(m_eob), 64'(v.eob && rem <= spp_eff));
                check("has_time", 64'(m_has_time), 64'(v.ht));
                if (v.ht) check("time", m_time, v.tm + 64'(pstart));
                if (idx == 0 && pkt == 1) t2 = m_time;
                rcv++;
                idx++;
                if (idx == plen) begin
                    $display("pkt %0d len %0d time %h eob %0d", pkt, plen, m_time, m_eob);
                    pkt++;
                    pstart += plen;
                    last_len = plen;
                    idx = 0;
                end
            end
            @(posedge ce_clk); #1;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        check("beats", 64'(rcv), 64'(total));
        check("pkts", 64'(pkt), 64'(v.pkts));
        if (v.pkts > 0) check("last_len", 64'(last_len), 64'(v.last));
        if (v.pkts > 1 && v.ht) check("time2", t2, v.t2);
        extra = 0;
        n = 0;
        do begin
            @(negedge ce_clk);
            if (m_tvalid) extra++;
            n++;
        end while (!s_hdr_tready && n < 10);
        check("back_to_idle", 64'(s_hdr_tready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge ce_clk);
            if (m_tvalid) extra++;
        end
        check("extra_beats", 64'(extra), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
        check({tag, "_m_tlast"}, 64'(m_tlast), 64'd0);
        check({tag, "_m_eob"}, 64'(m_eob), 64'd0);
        check({tag, "_m_has_time"}, 64'(m_has_time), 64'd0);
        check({tag, "_m_time"}, m_time, 64'd0);
        check({tag, "_m_tdata"}, 64'(m_tdata), 64'd0);
        check({tag, "_s_tready"}, 64'(s_tready), 64'd0);
        check({tag, "_s_hdr_tready"}, 64'(s_hdr_tready), 64'd0);
    endtask

    initial begin
        vec_t v;
        int rcv, n;
        vecs[0] = '{256, 4, 256, 64'h0123456789ABCDEF, 1'b1, 1'b1, 0, 4, 256, 64'h0123456789ABCEEF};
        vecs[1] = '{256, 3, 100, 64'h1000, 1'b1, 1'b0, 0, 2, 44, 64'h1100};
        vecs[2] = '{256, 1, 0, 64'h55, 1'b1, 1'b1, 0, 0, 0, 64'h0};
        vecs[3] = '{256, 1, 8, 64'h77, 1'b1, 1'b0, 0, 1, 8, 64'h0};
        vecs[4] = '{0, 1, 3, 64'h5, 1'b0, 1'b1, 0, 3, 1, 64'h0};
        vecs[5] = '{256, 2, 256, 64'hFFFFFFFFFFFFFF00, 1'b1, 1'b0, 0, 2, 256, 64'h0};
        vecs[6] = '{5, 2, 6, 64'h300, 1'b1, 1'b1, 10, 3, 2, 64'h305};
        vecs[7] = '{256, 40, 256, 64'h20, 1'b1, 1'b1, 25, 40, 256, 64'h120};

        repeat (3) @(posedge ce_clk);
        @(negedge ce_clk);
        check_reset_outputs("rst");
        @(posedge ce_clk); #1;
        ce_rst_n = 1'b1;
        @(negedge ce_clk);
        check("hdr_ready_first_cycle", 64'(s_hdr_tready), 64'd0);
        @(negedge ce_clk);
        check("hdr_ready_second_cycle", 64'(s_hdr_tready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            run_case(v, (i + 1) * 32'h10000);
        end

        // Reset in the middle of a burst after 100 output beats.
        send_hdr(256, 4, 256, 64'hABC, 1'b1, 1'b1);
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        rcv = 0;
        n = 0;
        while (rcv < 100 && n < 1000) begin
            s_tdata = 32'(rcv);
            @(negedge ce_clk);
            if (m_tvalid && m_tready) rcv++;
            n++;
            @(posedge ce_clk); #1;
        end
        check("beats_before_reset", 64'(rcv), 64'd100);
        ce_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge ce_clk);
        check("midrst_hold_m_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge ce_clk); #1;
        s_tvalid = 1'b0;
        ce_rst_n = 1'b1;
        v = '{256, 1, 16, 64'h4000, 1'b1, 1'b1, 0, 1, 16, 64'h0};
        run_case(v, 32'h900000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
